// File: rtl/fft_reorder_buffer.sv
// Ping-pong frame buffer behind the FFT core: bit-reversed to natural reordering,
// per-frame block exponent and error status, and dropping of malformed frames.
module fft_reorder_buffer #(
   parameter int DATA_W  = 8,
   parameter int LOG2N   = 6,
   parameter int EXP_W   = 6,
   parameter int REORDER = 1,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sink_valid,
   output logic              sink_ready,
   input  logic [1:0]        sink_error,
   input  logic              sink_sop,
   input  logic              sink_eop,
   input  logic [DATA_W-1:0] sink_real,
   input  logic [DATA_W-1:0] sink_imag,
   input  logic [EXP_W-1:0]  sink_exp,
   output logic              source_valid,
   input  logic              source_ready,
   output logic [1:0]        source_error,
   output logic              source_sop,
   output logic              source_eop,
   output logic [DATA_W-1:0] source_real,
   output logic [DATA_W-1:0] source_imag,
   output logic [EXP_W-1:0]  source_exp,
   output logic [CNT_W-1:0]  drop_count,
   output logic              busy
);

   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = {LOG2N{1'b1}};

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
      return r;
   endfunction

   logic [2*DATA_W-1:0] r_mem [2][N];
   logic [EXP_W-1:0]    r_exp [2];
   logic [1:0]          r_err [2];
   logic [1:0]          r_full;

   logic                r_wbank;
   logic [LOG2N-1:0]    r_wc;
   logic                r_errAcc;
   logic                r_strayRun;
   logic [CNT_W-1:0]    r_drop;

   logic                r_rbank;
   logic [LOG2N-1:0]    r_rc;
   logic                r_oValid;
   logic                r_oSop;
   logic                r_oEop;
   logic [DATA_W-1:0]   r_oReal;
   logic [DATA_W-1:0]   r_oImag;
   logic [EXP_W-1:0]    r_oExp;
   logic [1:0]          r_oErr;

   logic                w_wr;
   logic                w_stray;
   logic                w_restart;
   logic                w_last;
   logic                w_early;
   logic                w_close;
   logic                w_store;
   logic                w_errBit;
   logic                w_dropInc;
   logic [LOG2N-1:0]    w_effWc;
   logic [LOG2N-1:0]    w_wAddr;
   logic                w_issue;
   logic                w_issueLast;
   logic [2*DATA_W-1:0] w_rdData;

   // A sop beat always lands at frame position 0, even when it cuts a partial frame short.
   assign w_wr      = sink_valid && sink_ready;
   assign w_effWc   = sink_sop ? '0 : r_wc;
   assign w_stray   = !sink_sop && (r_wc == '0);
   assign w_restart = sink_sop && (r_wc != '0);
   assign w_last    = !w_stray && (w_effWc == LAST);
   assign w_early   = !w_stray && sink_eop && !w_last;
   assign w_close   = w_wr && w_last;
   assign w_store   = w_wr && !w_stray && !w_early;
   assign w_errBit  = (sink_sop ? 1'b0 : r_errAcc) | (sink_error != 2'b00);
   assign w_dropInc = w_wr && (w_restart || w_early || (w_stray && !r_strayRun));
   assign w_wAddr   = (REORDER != 0) ? bitrev(w_effWc) : w_effWc;

   // The bank is freed once its last entry has moved into the output register,
   // which keeps the writer from stalling between back-to-back frames.
   assign w_issue     = r_full[r_rbank] && (!r_oValid || source_ready);
   assign w_issueLast = w_issue && (r_rc == LAST);
   assign w_rdData    = r_mem[r_rbank][r_rc];

   assign sink_ready   = !r_full[r_wbank];
   assign busy         = r_full[0] || r_full[1] || (r_wc != '0);
   assign drop_count   = r_drop;
   assign source_valid = r_oValid;
   assign source_sop   = r_oSop;
   assign source_eop   = r_oEop;
   assign source_real  = r_oReal;
   assign source_imag  = r_oImag;
   assign source_exp   = r_oExp;
   assign source_error = r_oErr;

   always_ff @(posedge clk) begin
      if (w_store) r_mem[r_wbank][w_wAddr] <= {sink_real, sink_imag};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full     <= '0;
         r_wbank    <= 1'b0;
         r_wc       <= '0;
         r_errAcc   <= 1'b0;
         r_strayRun <= 1'b0;
         r_drop     <= '0;
         for (int b = 0; b < 2; b++) begin
            r_exp[b] <= '0;
            r_err[b] <= '0;
         end
      end else begin
         if (w_wr) begin
            r_strayRun <= w_stray;
            if (sink_sop) r_exp[r_wbank] <= sink_exp;
            if (w_store) r_errAcc <= w_errBit;
            if (w_close) begin
               r_err[r_wbank] <= {~sink_eop, w_errBit};
               r_wbank        <= ~r_wbank;
               r_wc           <= '0;
            end else if (w_early) begin
               r_wc <= '0;
            end else if (w_store) begin
               r_wc <= w_effWc + 1'b1;
            end
         end
         if (w_dropInc && (r_drop != {CNT_W{1'b1}})) r_drop <= r_drop + 1'b1;
         // The writer only touches an empty bank and the reader only frees a full one.
         for (int b = 0; b < 2; b++) begin
            if (w_close && (r_wbank == 1'(b)))          r_full[b] <= 1'b1;
            else if (w_issueLast && (r_rbank == 1'(b))) r_full[b] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rbank  <= 1'b0;
         r_rc     <= '0;
         r_oValid <= 1'b0;
         r_oSop   <= 1'b0;
         r_oEop   <= 1'b0;
         r_oReal  <= '0;
         r_oImag  <= '0;
         r_oExp   <= '0;
         r_oErr   <= '0;
      end else if (w_issue) begin
         r_rc     <= r_rc + 1'b1;
         if (w_issueLast) r_rbank <= ~r_rbank;
         r_oValid <= 1'b1;
         r_oSop   <= (r_rc == '0);
         r_oEop   <= (r_rc == LAST);
         r_oReal  <= w_rdData[2*DATA_W-1:DATA_W];
         r_oImag  <= w_rdData[DATA_W-1:0];
         r_oExp   <= r_exp[r_rbank];
         r_oErr   <= r_err[r_rbank];
      end else if (r_oValid && source_ready) begin
         r_oValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer: a reordering and a pass-through instance share one
// input stream and are checked every cycle against a frame-level model.
module tb_fft_reorder_buffer;

   localparam int DW = 8;
   localparam int L  = 3;
   localparam int N  = 8;
   localparam int EW = 6;
   localparam int CW = 2;
   localparam int DROP_MAX = 3;

   typedef struct packed {
      logic [7:0] re;
      logic [7:0] im;
   } sample_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          sinkValid, sinkSop, sinkEop;
   logic [1:0]    sinkErr;
   logic [DW-1:0] sinkReal, sinkImag;
   logic [EW-1:0] sinkExp;
   logic          sourceReady;

   logic          sinkReady [2];
   logic          srcValid  [2];
   logic          srcSop    [2];
   logic          srcEop    [2];
   logic [1:0]    srcErr    [2];
   logic [DW-1:0] srcReal   [2];
   logic [DW-1:0] srcImag   [2];
   logic [EW-1:0] srcExp    [2];
   logic [CW-1:0] dropCnt   [2];
   logic          busyOut   [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   sample_t    frames [$];
   logic [5:0] frExp [$];
   logic [1:0] frErr [$];
   sample_t    cur [$];
   logic [5:0] curExp;
   logic       curErr;
   bit         strayRun;
   int         modelDrops;
   int         outIdx [2];
   logic [7:0] logR0 [$];
   logic [7:0] logR1 [$];
   logic [1:0] logErr0 [$];
   int         hsCyc [$];
   bit         streamChk = 1'b0;

   fft_reorder_buffer #(.DATA_W(DW), .LOG2N(L), .EXP_W(EW), .REORDER(1), .CNT_W(CW)) u_dutRev (
      .clk(clk), .reset_n(reset_n),
      .sink_valid(sinkValid), .sink_ready(sinkReady[0]), .sink_error(sinkErr),
      .sink_sop(sinkSop), .sink_eop(sinkEop), .sink_real(sinkReal), .sink_imag(sinkImag),
      .sink_exp(sinkExp),
      .source_valid(srcValid[0]), .source_ready(sourceReady), .source_error(srcErr[0]),
      .source_sop(srcSop[0]), .source_eop(srcEop[0]), .source_real(srcReal[0]),
      .source_imag(srcImag[0]), .source_exp(srcExp[0]),
      .drop_count(dropCnt[0]), .busy(busyOut[0])
   );

   fft_reorder_buffer #(.DATA_W(DW), .LOG2N(L), .EXP_W(EW), .REORDER(0), .CNT_W(CW)) u_dutNat (
      .clk(clk), .reset_n(reset_n),
      .sink_valid(sinkValid), .sink_ready(sinkReady[1]), .sink_error(sinkErr),
      .sink_sop(sinkSop), .sink_eop(sinkEop), .sink_real(sinkReal), .sink_imag(sinkImag),
      .sink_exp(sinkExp),
      .source_valid(srcValid[1]), .source_ready(sourceReady), .source_error(srcErr[1]),
      .source_sop(srcSop[1]), .source_eop(srcEop[1]), .source_real(srcReal[1]),
      .source_imag(srcImag[1]), .source_exp(srcExp[1]),
      .drop_count(dropCnt[1]), .busy(busyOut[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Output position p of a reordered frame holds the input sample whose index reverses to p.
   function automatic int rev3(input int p);
      return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
   endfunction

   // Compare every meaningful output cycle first, then fold the beat about to be accepted into the model.
   always @(negedge clk) begin
      int f, p, k;
      bit dropped;
      bit beatErr;
      sample_t s;
      logic [31:0] expV, actV;
      if (!reset_n) begin
         frames.delete(); frExp.delete(); frErr.delete(); cur.delete();
         strayRun = 1'b0;
         modelDrops = 0;
         outIdx[0] = 0;
         outIdx[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (srcValid[i]) begin
               if (outIdx[i] >= frames.size()) begin
                  checkOutput(i == 0 ? "out_rev_extra" : "out_nat_extra", 32'd1, 32'd0);
               end else begin
                  f = outIdx[i] / N;
                  p = outIdx[i] % N;
                  k = (i == 0) ? rev3(p) : p;
                  s = frames[f*N + k];
                  expV = {6'b0, s.re, s.im, p == 0, p == N-1, frExp[f], frErr[f]};
                  actV = {6'b0, srcReal[i], srcImag[i], srcSop[i], srcEop[i], srcExp[i], srcErr[i]};
                  checkOutput(i == 0 ? "out_rev" : "out_nat", actV, expV);
               end
               if (sourceReady) begin
                  outIdx[i]++;
                  if (i == 0) begin
                     logR0.push_back(srcReal[0]);
                     logErr0.push_back(srcErr[0]);
                     if (streamChk) hsCyc.push_back(cyc);
                  end else begin
                     logR1.push_back(srcReal[1]);
                  end
               end
            end
            checkOutput(i == 0 ? "drop_rev" : "drop_nat", {30'b0, dropCnt[i]}, 32'(modelDrops));
         end

         if (sinkValid && sinkReady[0]) begin
            dropped = 1'b0;
            beatErr = (sinkErr != 2'b00);
            if (sinkSop) begin
               if (cur.size() > 0) dropped = 1'b1;
               cur.delete();
               cur.push_back({sinkReal, sinkImag});
               curExp = sinkExp;
               curErr = beatErr;
               strayRun = 1'b0;
               if (sinkEop) begin
                  cur.delete();
                  dropped = 1'b1;
               end
            end else if (cur.size() == 0) begin
               if (!strayRun) dropped = 1'b1;
               strayRun = 1'b1;
            end else begin
               cur.push_back({sinkReal, sinkImag});
               curErr = curErr | beatErr;
               if (cur.size() == N) begin
                  foreach (cur[j]) frames.push_back(cur[j]);
                  frExp.push_back(curExp);
                  frErr.push_back({~sinkEop, curErr});
                  cur.delete();
               end else if (sinkEop) begin
                  cur.delete();
                  dropped = 1'b1;
               end
            end
            if (dropped && modelDrops < DROP_MAX) modelDrops++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat, hold it until accepted, then return one step after the accepting edge.
   task automatic applyStimulus(input bit sop, input bit eop, input logic [1:0] err,
                                input logic [7:0] re, input logic [7:0] im, input logic [5:0] ex);
      int waitCyc = 0;
      sinkValid = 1'b1;
      sinkSop   = sop;
      sinkEop   = eop;
      sinkErr   = err;
      sinkReal  = re;
      sinkImag  = im;
      sinkExp   = ex;
      @(negedge clk);
      while (!sinkReady[0] && waitCyc < 200) begin
         @(negedge clk);
         waitCyc++;
      end
      if (!sinkReady[0]) checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      sinkValid = 1'b0;
      sinkSop   = 1'b0;
      sinkEop   = 1'b0;
      sinkErr   = 2'b00;
   endtask

   task automatic sendFrame(input logic [7:0] base, input logic [5:0] ex, input int nBeats,
                            input int errBeat, input bit eopLast, input bit rev);
      for (int k = 0; k < nBeats; k++) begin
         logic [2:0] kb;
         logic [7:0] pv;
         kb = 3'(k);
         pv = rev ? {5'b0, kb[0], kb[1], kb[2]} : {5'b0, kb};
         applyStimulus(k == 0, eopLast && (k == nBeats-1), (k == errBeat) ? 2'b01 : 2'b00,
                       base + pv, (base ^ 8'h5A) + 8'(k), ex);
      end
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((outIdx[0] != frames.size() || outIdx[1] != frames.size()) && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 400) checkOutput("drain_timeout", 32'd0, 32'd1);
      idle(2);
   endtask

   initial begin
      int sz;
      int t0;
      reset_n = 1'b0;
      sinkValid = 1'b0; sinkSop = 1'b0; sinkEop = 1'b0; sinkErr = 2'b00;
      sinkReal = '0; sinkImag = '0; sinkExp = '0;
      sourceReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_valid", {31'b0, srcValid[0]}, 32'd0);
      checkOutput("rst_sink_ready", {31'b0, sinkReady[0]}, 32'd1);
      checkOutput("rst_drop", {30'b0, dropCnt[0]}, 32'd0);
      checkOutput("rst_busy", {31'b0, busyOut[0]}, 32'd0);
      reset_n = 1'b1;
      idle(2);

      $display("[TB] reorder frame and latency");
      sendFrame(8'h00, 6'd5, 8, -1, 1'b1, 1'b1);
      checkOutput("lat_cycle1", {31'b0, srcValid[0]}, 32'd0);
      idle(1);
      checkOutput("lat_cycle2", {31'b0, srcValid[0]}, 32'd1);
      checkOutput("first_sop", {31'b0, srcSop[0]}, 32'd1);
      checkOutput("first_exp", {26'b0, srcExp[0]}, 32'd5);
      checkOutput("first_err", {30'b0, srcErr[0]}, 32'd0);
      waitDrain();
      for (int p = 0; p < N; p++) checkOutput("natural_order", {24'b0, logR0[p]}, 32'(p));
      checkOutput("passthru_1", {24'b0, logR1[1]}, 32'd4);
      checkOutput("passthru_3", {24'b0, logR1[3]}, 32'd6);
      checkOutput("idle_busy", {31'b0, busyOut[0]}, 32'd0);

      $display("[TB] streaming");
      streamChk = 1'b1;
      t0 = cyc;
      for (int fr = 0; fr < 4; fr++) sendFrame(8'(16 * (fr + 1)), 6'(fr + 1), 8, -1, 1'b1, 1'b0);
      checkOutput("stream_in_cycles", 32'(cyc - t0), 32'd32);
      waitDrain();
      streamChk = 1'b0;
      checkOutput("stream_beats", 32'(hsCyc.size()), 32'd32);
      if (hsCyc.size() == 32) checkOutput("stream_no_bubble", 32'(hsCyc[31] - hsCyc[0]), 32'd31);

      $display("[TB] backpressure");
      sourceReady = 1'b0;
      sendFrame(8'h80, 6'd7, 8, -1, 1'b1, 1'b0);
      sendFrame(8'h90, 6'd8, 8, -1, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("bp_sink_ready", {31'b0, sinkReady[0]}, 32'd0);
      checkOutput("bp_hold_sop", {31'b0, srcSop[0]}, 32'd1);
      @(posedge clk);
      #1;
      fork
         begin
            idle(4);
            sourceReady = 1'b1;
         end
         sendFrame(8'hA0, 6'd9, 8, -1, 1'b1, 1'b0);
      join
      waitDrain();

      $display("[TB] framing faults");
      sendFrame(8'h10, 6'd2, 3, -1, 1'b0, 1'b0);
      sendFrame(8'h20, 6'd3, 8, -1, 1'b1, 1'b0);
      waitDrain();
      checkOutput("drop_sop_mid", {30'b0, dropCnt[0]}, 32'd1);
      sz = logR1.size();
      checkOutput("restart_first", {24'b0, logR1[sz-8]}, 32'h20);
      checkOutput("restart_last", {24'b0, logR1[sz-1]}, 32'h27);
      sendFrame(8'h30, 6'd4, 6, -1, 1'b1, 1'b0);
      idle(2);
      checkOutput("drop_early_eop", {30'b0, dropCnt[0]}, 32'd2);
      for (int s = 0; s < 3; s++) applyStimulus(1'b0, 1'b0, 2'b00, 8'h55, 8'h66, 6'd0);
      idle(2);
      checkOutput("drop_stray", {30'b0, dropCnt[0]}, 32'd3);
      sendFrame(8'h40, 6'd5, 2, -1, 1'b0, 1'b0);
      sendFrame(8'h50, 6'd6, 8, -1, 1'b1, 1'b0);
      waitDrain();
      checkOutput("drop_saturate", {30'b0, dropCnt[0]}, 32'd3);

      $display("[TB] error propagation");
      sendFrame(8'h60, 6'd6, 8, 4, 1'b1, 1'b0);
      waitDrain();
      sz = logErr0.size();
      checkOutput("err_beat4_sop", {30'b0, logErr0[sz-8]}, 32'd1);
      checkOutput("err_beat4_eop", {30'b0, logErr0[sz-1]}, 32'd1);
      sendFrame(8'h70, 6'd7, 8, -1, 1'b0, 1'b0);
      waitDrain();
      sz = logErr0.size();
      checkOutput("err_no_eop_sop", {30'b0, logErr0[sz-8]}, 32'd2);
      checkOutput("err_no_eop_eop", {30'b0, logErr0[sz-1]}, 32'd2);

      $display("[TB] reset mid-frame");
      sourceReady = 1'b0;
      sendFrame(8'h88, 6'd1, 8, -1, 1'b1, 1'b0);
      sendFrame(8'h98, 6'd2, 5, -1, 1'b0, 1'b0);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("mrst_valid", {31'b0, srcValid[0]}, 32'd0);
      checkOutput("mrst_outputs", {6'b0, srcReal[0], srcImag[0], srcSop[0], srcEop[0], srcExp[0], srcErr[0]}, 32'd0);
      checkOutput("mrst_sink_ready", {31'b0, sinkReady[0]}, 32'd1);
      checkOutput("mrst_busy", {31'b0, busyOut[0]}, 32'd0);
      checkOutput("mrst_drop", {30'b0, dropCnt[0]}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      sourceReady = 1'b1;
      idle(3);
      checkOutput("no_residue", {31'b0, srcValid[0]}, 32'd0);
      sendFrame(8'hC0, 6'd3, 8, -1, 1'b1, 1'b1);
      waitDrain();
      sz = logR0.size();
      checkOutput("post_rst_first", {24'b0, logR0[sz-8]}, 32'hC0);
      checkOutput("post_rst_last", {24'b0, logR0[sz-1]}, 32'hC7);
      checkOutput("drained_rev", 32'(outIdx[0]), 32'(frames.size()));
      checkOutput("drained_nat", 32'(outIdx[1]), 32'(frames.size()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
